// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit: tracks in-flight destination tags,
// resolves each source to its newest producer and stalls on load-use hazards.
module fwd_hazard_unit #(
  parameter int AW         = 3,
  parameter int DW         = 16,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        hold,
  input  logic                                        issue_valid,
  input  logic [AW-1:0]                               issue_rd,
  input  logic                                        issue_reg_write,
  input  logic                                        issue_is_load,
  input  logic [NUM_SRC*AW-1:0]                       src_addr,
  input  logic [NUM_SRC-1:0]                          src_used,
  input  logic [NUM_SRC*DW-1:0]                       rf_data,
  input  logic [FWD_STAGES*DW-1:0]                    stage_data,
  output logic                                        stall,
  output logic [NUM_SRC*$clog2(FWD_STAGES+1)-1:0]     fwd_sel,
  output logic [NUM_SRC*DW-1:0]                       fwd_data,
  output logic [CNT_W-1:0]                            stall_count
);

  localparam int SEL_W = $clog2(FWD_STAGES+1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          wr;
    logic          ld;
  } tag_t;

  tag_t tags [FWD_STAGES];

  logic             hazard_any;
  logic             haz;
  logic [SEL_W-1:0] sel;
  logic [DW-1:0]    data;
  logic [AW-1:0]    src;

  // Scan oldest to newest so the youngest matching producer overwrites older ones.
  always_comb begin
    hazard_any = 1'b0;
    fwd_sel    = '0;
    fwd_data   = '0;
    haz        = 1'b0;
    sel        = '0;
    data       = '0;
    src        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src  = src_addr[k*AW +: AW];
      sel  = '0;
      data = rf_data[k*DW +: DW];
      haz  = 1'b0;
      for (int i = FWD_STAGES-1; i >= 0; i--) begin
        if (tags[i].valid && tags[i].wr && src_used[k] && (tags[i].rd == src) &&
            !((ZERO_REG != 0) && (src == '0))) begin
          sel  = SEL_W'(i + 1);
          data = stage_data[i*DW +: DW];
          haz  = (i == 0) && tags[i].ld;
        end
      end
      fwd_sel[k*SEL_W +: SEL_W] = sel;
      fwd_data[k*DW +: DW]      = data;
      hazard_any                = hazard_any | haz;
    end
  end

  assign stall = issue_valid && hazard_any;

  // A stalled issue enters the tag pipeline as a bubble so the load can advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FWD_STAGES; i++) begin
        tags[i] <= '0;
      end
      stall_count <= '0;
    end else if (!hold) begin
      if (issue_valid && !stall) begin
        tags[0] <= '{valid: 1'b1, rd: issue_rd, wr: issue_reg_write, ld: issue_is_load};
      end else begin
        tags[0] <= '0;
      end
      for (int i = 1; i < FWD_STAGES; i++) begin
        tags[i] <= tags[i-1];
      end
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule
